// File: rtl/depth_book_levels.sv
// Two-sided price-level book: one sorted level array per side, updated by
// absolute-quantity depth events through an IDLE/APPLY/PUBLISH sequencer.

module depth_book_side #(
    parameter int DEPTH  = 8,
    parameter int PX_W   = 32,
    parameter int QTY_W  = 32,
    parameter bit IS_ASK = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd,
    input  logic [PX_W-1:0]  price,
    input  logic [QTY_W-1:0] qty,
    output logic [PX_W-1:0]  top_px,
    output logic [QTY_W-1:0] top_qty,
    output logic [4:0]       count,
    output logic             miss,
    output logic             evict
);
    logic [DEPTH-1:0][PX_W-1:0]  px_q, px_d, px_up, px_dn;
    logic [DEPTH-1:0][QTY_W-1:0] qty_q, qty_d, qty_up, qty_dn;
    logic [4:0]                  cnt_q, cnt_d;
    logic [DEPTH-1:0]            vld, match, ins, after;
    logic                        hit, full, run, prev_ins;

    // Unused slots are kept zero so shifting in from past the end is harmless.
    assign px_up  = {{PX_W{1'b0}}, px_q[DEPTH-1:1]};
    assign px_dn  = {px_q[DEPTH-2:0], {PX_W{1'b0}}};
    assign qty_up = {{QTY_W{1'b0}}, qty_q[DEPTH-1:1]};
    assign qty_dn = {qty_q[DEPTH-2:0], {QTY_W{1'b0}}};

    always_comb begin
        run = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            vld[i]   = 5'(i) < cnt_q;
            match[i] = vld[i] && (px_q[i] == price);
            // ins marks slots that the new level or a shifted-down level lands in
            ins[i]   = !vld[i] || (IS_ASK ? (price < px_q[i]) : (price > px_q[i]));
            run      = run | match[i];
            after[i] = run;
        end
    end

    assign hit  = |match;
    assign full = (cnt_q == 5'(DEPTH));

    always_comb begin
        px_d     = px_q;
        qty_d    = qty_q;
        cnt_d    = cnt_q;
        miss     = 1'b0;
        evict    = 1'b0;
        prev_ins = 1'b0;
        if (hit) begin
            if (qty != '0) begin
                for (int i = 0; i < DEPTH; i++)
                    if (match[i]) qty_d[i] = qty;
            end else begin
                for (int i = 0; i < DEPTH; i++)
                    if (after[i]) begin
                        px_d[i]  = px_up[i];
                        qty_d[i] = qty_up[i];
                    end
                cnt_d = cnt_q - 5'd1;
            end
        end else if (qty == '0) begin
            miss = 1'b1;
        end else if (full && !ins[DEPTH-1]) begin
            evict = 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ins[i]) begin
                    px_d[i]  = prev_ins ? px_dn[i]  : price;
                    qty_d[i] = prev_ins ? qty_dn[i] : qty;
                end
                prev_ins = ins[i];
            end
            evict = full;
            cnt_d = full ? cnt_q : cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q  <= '0;
            qty_q <= '0;
            cnt_q <= '0;
        end else if (upd) begin
            px_q  <= px_d;
            qty_q <= qty_d;
            cnt_q <= cnt_d;
        end
    end

    assign top_px  = px_q[0];
    assign top_qty = qty_q[0];
    assign count   = cnt_q;
endmodule

module depth_book_levels #(
    parameter int DEPTH = 8,
    parameter int PX_W  = 32,
    parameter int QTY_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ev_valid,
    output logic             ev_ready,
    input  logic             ev_side,
    input  logic [PX_W-1:0]  ev_price,
    input  logic [QTY_W-1:0] ev_qty,
    input  logic [63:0]      ev_update_id,
    output logic [PX_W-1:0]  best_bid_px,
    output logic [QTY_W-1:0] best_bid_qty,
    output logic [PX_W-1:0]  best_ask_px,
    output logic [QTY_W-1:0] best_ask_qty,
    output logic [4:0]       bid_count,
    output logic [4:0]       ask_count,
    output logic             bbo_valid,
    output logic             crossed,
    output logic [15:0]      stale_cnt,
    output logic [15:0]      miss_cnt,
    output logic [15:0]      evict_cnt
);
    typedef enum logic [1:0] {IDLE, APPLY, PUBLISH} state_t;

    state_t            state_q, state_d;
    logic              side_q;
    logic [PX_W-1:0]   px_q;
    logic [QTY_W-1:0]  qty_q;
    logic [63:0]       id_q, last_id_q;
    logic              first_q;
    logic              stale, apply_ok, cross_now;

    logic [1:0][PX_W-1:0]  top_px;
    logic [1:0][QTY_W-1:0] top_qty;
    logic [1:0][4:0]       cnt;
    logic [1:0]            upd, miss, evict;

    assign stale    = !first_q && (id_q <= last_id_q);
    assign apply_ok = (state_q == APPLY) && !stale;
    assign ev_ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ev_valid) state_d = APPLY;
            APPLY:   state_d = stale ? IDLE : PUBLISH;
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar s = 0; s < 2; s++) begin : g_side
        assign upd[s] = apply_ok && (side_q == 1'(s));
        depth_book_side #(
            .DEPTH (DEPTH),
            .PX_W  (PX_W),
            .QTY_W (QTY_W),
            .IS_ASK(s == 1)
        ) u_side (
            .clk    (clk),
            .rst_n  (rst_n),
            .upd    (upd[s]),
            .price  (px_q),
            .qty    (qty_q),
            .top_px (top_px[s]),
            .top_qty(top_qty[s]),
            .count  (cnt[s]),
            .miss   (miss[s]),
            .evict  (evict[s])
        );
    end

    assign cross_now = (cnt[0] != 5'd0) && (cnt[1] != 5'd0) && (top_px[0] >= top_px[1]);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            side_q       <= 1'b0;
            px_q         <= '0;
            qty_q        <= '0;
            id_q         <= '0;
            last_id_q    <= '0;
            first_q      <= 1'b1;
            best_bid_px  <= '0;
            best_bid_qty <= '0;
            best_ask_px  <= '0;
            best_ask_qty <= '0;
            bid_count    <= '0;
            ask_count    <= '0;
            bbo_valid    <= 1'b0;
            crossed      <= 1'b0;
            stale_cnt    <= '0;
            miss_cnt     <= '0;
            evict_cnt    <= '0;
        end else begin
            state_q   <= state_d;
            bbo_valid <= 1'b0;
            if (state_q == IDLE && ev_valid) begin
                side_q <= ev_side;
                px_q   <= ev_price;
                qty_q  <= ev_qty;
                id_q   <= ev_update_id;
            end
            if (state_q == APPLY) begin
                if (stale) begin
                    stale_cnt <= sat_inc(stale_cnt);
                end else begin
                    last_id_q <= id_q;
                    first_q   <= 1'b0;
                    if (miss[side_q])  miss_cnt  <= sat_inc(miss_cnt);
                    if (evict[side_q]) evict_cnt <= sat_inc(evict_cnt);
                end
            end
            if (state_q == PUBLISH) begin
                best_bid_px  <= top_px[0];
                best_bid_qty <= top_qty[0];
                best_ask_px  <= top_px[1];
                best_ask_qty <= top_qty[1];
                bid_count    <= cnt[0];
                ask_count    <= cnt[1];
                crossed      <= cross_now;
                bbo_valid    <= 1'b1;
            end
        end
    end
endmodule
